// File: rtl/led_display_package.sv
// Shared types and constants for the LED panel capture front-end.
package led_display_package;

  typedef enum logic [1:0] {
    PXL_RED   = 2'd0,
    PXL_GREEN = 2'd1,
    PXL_BLUE  = 2'd2
  } pxl_col_t;

  typedef enum logic {
    CAP_IDLE  = 1'b0,
    CAP_SHIFT = 1'b1
  } cap_state_t;

  localparam int unsigned CAP_SYNC_STAGES = 2;
  localparam int unsigned CAP_NUM_LINES   = 3;

endpackage

// File: rtl/led_display_sync_edge.sv
// N-bit multi-flop synchroniser with optional rising-edge detect on the synced level.
module led_display_sync_edge
  import led_display_package::*;
#(
  parameter int unsigned WIDTH   = 1,
  parameter bit          EDGE_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise_c
);

  logic [CAP_SYNC_STAGES-1:0][WIDTH-1:0] stages;

  always_ff @(posedge clk) begin
    if (reset) begin
      stages <= '0;
    end else begin
      stages <= {stages[CAP_SYNC_STAGES-2:0], d};
    end
  end

  assign q = stages[CAP_SYNC_STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic [WIDTH-1:0] prev;
      always_ff @(posedge clk) begin
        if (reset) begin
          prev <= '0;
        end else begin
          prev <= q;
        end
      end
      assign rise_c = q & ~prev;
    end else begin : g_no_edge
      assign rise_c = '0;
    end
  endgenerate

endmodule

// File: rtl/led_display_capture_phy.sv
// LED panel serial column receiver: deserialises one row per colour line onto a valid/ready port.
// Optional feature: define LED_CAPTURE_ROW_CNT_EN to add the row_count_out counter.
module led_display_capture_phy
  import led_display_package::*;
#(
  parameter int unsigned NUM_COLS       = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                                    clk_in,
  input  logic                                    reset_in,
  input  logic                                    bit_clk_in,
  input  logic [2:0]                              rgb_top_in,
  input  logic [2:0]                              rgb_bot_in,
  input  logic                                    le_in,
  output logic [CAP_NUM_LINES-1:0][NUM_COLS-1:0]  col_top_out,
  output logic [CAP_NUM_LINES-1:0][NUM_COLS-1:0]  col_bot_out,
  output logic                                    valid_out,
  input  logic                                    ready_in,
  output logic                                    overflow_out,
  output logic                                    short_row_out,
  input  logic                                    clear_err_in
`ifdef LED_CAPTURE_ROW_CNT_EN
  ,
  output logic [15:0]                             row_count_out
`endif
);

  localparam int unsigned CNT_W  = $clog2(NUM_COLS + 1);
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0] ctrl_unused_q;
  logic [1:0] ctrl_rise;
  logic [5:0] rgb_q;
  logic [5:0] rgb_unused_rise;
  logic       bclk_rise;
  logic       le_rise;

  led_display_sync_edge #(.WIDTH(2), .EDGE_EN(1'b1)) u_ctrl_sync (
    .clk    (clk_in),
    .reset  (reset_in),
    .d      ({le_in, bit_clk_in}),
    .q      (ctrl_unused_q),
    .rise_c (ctrl_rise)
  );

  led_display_sync_edge #(.WIDTH(6), .EDGE_EN(1'b0)) u_rgb_sync (
    .clk    (clk_in),
    .reset  (reset_in),
    .d      ({rgb_bot_in, rgb_top_in}),
    .q      (rgb_q),
    .rise_c (rgb_unused_rise)
  );

  assign bclk_rise = ctrl_rise[0];
  assign le_rise   = ctrl_rise[1];

  cap_state_t                              state;
  logic [CNT_W-1:0]                        bit_cnt;
  logic [IDLE_W-1:0]                       idle_cnt;
  logic [CAP_NUM_LINES-1:0][NUM_COLS-1:0]  shift_top;
  logic [CAP_NUM_LINES-1:0][NUM_COLS-1:0]  shift_bot;
  logic [CAP_NUM_LINES-1:0][NUM_COLS-1:0]  top_nxt_c;
  logic [CAP_NUM_LINES-1:0][NUM_COLS-1:0]  bot_nxt_c;
  logic                                    last_bit_c;
  logic                                    buf_free_c;
  logic                                    timeout_c;

  // First received bit travels up to the MSB of each colour word.
  always_comb begin
    top_nxt_c = '0;
    bot_nxt_c = '0;
    for (int c = 0; c < int'(CAP_NUM_LINES); c++) begin
      top_nxt_c[c] = {shift_top[c][NUM_COLS-2:0], rgb_q[c]};
      bot_nxt_c[c] = {shift_bot[c][NUM_COLS-2:0], rgb_q[CAP_NUM_LINES+c]};
    end
  end

  assign last_bit_c = (bit_cnt == CNT_W'(NUM_COLS - 1));
  assign buf_free_c = !valid_out || ready_in;
  assign timeout_c  = (idle_cnt == IDLE_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state         <= CAP_IDLE;
      bit_cnt       <= '0;
      idle_cnt      <= '0;
      shift_top     <= '0;
      shift_bot     <= '0;
      col_top_out   <= '0;
      col_bot_out   <= '0;
      valid_out     <= 1'b0;
      overflow_out  <= 1'b0;
      short_row_out <= 1'b0;
`ifdef LED_CAPTURE_ROW_CNT_EN
      row_count_out <= '0;
`endif
    end else begin
      if (valid_out && ready_in) begin
        valid_out <= 1'b0;
      end
      // Error events below override a same-cycle clear.
      if (clear_err_in) begin
        overflow_out  <= 1'b0;
        short_row_out <= 1'b0;
      end
      case (state)
        CAP_IDLE: begin
          if (bclk_rise) begin
            state     <= CAP_SHIFT;
            bit_cnt   <= CNT_W'(1);
            idle_cnt  <= '0;
            shift_top <= top_nxt_c;
            shift_bot <= bot_nxt_c;
          end
        end
        CAP_SHIFT: begin
          if (le_rise || timeout_c) begin
            short_row_out <= 1'b1;
            state         <= CAP_IDLE;
            bit_cnt       <= '0;
            idle_cnt      <= '0;
            shift_top     <= '0;
            shift_bot     <= '0;
          end else if (bclk_rise) begin
            idle_cnt <= '0;
            if (last_bit_c) begin
              state   <= CAP_IDLE;
              bit_cnt <= '0;
              if (buf_free_c) begin
                col_top_out <= top_nxt_c;
                col_bot_out <= bot_nxt_c;
                valid_out   <= 1'b1;
`ifdef LED_CAPTURE_ROW_CNT_EN
                row_count_out <= row_count_out + 16'd1;
`endif
              end else begin
                overflow_out <= 1'b1;
              end
            end else begin
              bit_cnt   <= bit_cnt + CNT_W'(1);
              shift_top <= top_nxt_c;
              shift_bot <= bot_nxt_c;
            end
          end else begin
            // Never passes TIMEOUT_CYCLES: reaching it aborts the row above.
            idle_cnt <= idle_cnt + IDLE_W'(1);
          end
        end
        default: state <= CAP_IDLE;
      endcase
    end
  end

endmodule
